// File: rtl/crc7_serial_checker_pkg.sv
// Shared CRC-7 constants and FSM encoding for the SD/MMC command CRC
// checker and encoder.
package crc7_serial_checker_pkg;

    localparam int             CRC7_W    = 7;
    localparam logic [CRC7_W-1:0] CRC7_POLY = 7'h09;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EVAL  = 2'd2
    } state_t;

endpackage

// File: rtl/crc7_lfsr_step.sv
// One serial step of the CRC-7 LFSR, shared by checker and encoder.
// Ports: crc_in (current remainder), bit_in (next frame bit), crc_out.
module crc7_lfsr_step
    import crc7_serial_checker_pkg::*;
#(
    parameter logic [CRC7_W-1:0] POLY = CRC7_POLY
) (
    input  logic [CRC7_W-1:0] crc_in,
    input  logic              bit_in,
    output logic [CRC7_W-1:0] crc_out
);

    logic fb;

    assign fb      = crc_in[CRC7_W-1] ^ bit_in;
    assign crc_out = {crc_in[CRC7_W-2:0], 1'b0}
                   ^ (fb ? POLY : '0);

endmodule

// File: rtl/crc7_serial_checker.sv
// Serial CRC-7 checker: accumulates bits while en_check is high and,
// after the window closes, reports remainder, length and status.
// Ports: clk, reset (sync, active-high), en_check, bit_valid, bit_in
//        -> busy, done, crc_ok, crc_err, len_err, bit_count, syndrome.
module crc7_serial_checker
    import crc7_serial_checker_pkg::*;
#(
    parameter logic [CRC7_W-1:0] POLY     = CRC7_POLY,
    parameter logic [CRC7_W-1:0] INIT     = 7'h00,
    parameter int                MIN_BITS = 8,
    parameter int                MAX_BITS = 128,
    parameter int                CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_check,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              busy,
    output logic              done,
    output logic              crc_ok,
    output logic              crc_err,
    output logic              len_err,
    output logic [CNT_W-1:0]  bit_count,
    output logic [CRC7_W-1:0] syndrome
);

    state_t             state;
    state_t             state_nxt;
    logic [CRC7_W-1:0]  crc;
    logic [CRC7_W-1:0]  step_in;
    logic [CRC7_W-1:0]  step_out;
    logic               ovf;
    logic               full;
    logic               short_len;
    logic               bad_len;

    // Bit 0 of a window is shifted from the seed, not the stale remainder.
    assign step_in = (state == IDLE) ? INIT : crc;

    crc7_lfsr_step #(
        .POLY (POLY)
    ) u_step (
        .crc_in  (step_in),
        .bit_in  (bit_in),
        .crc_out (step_out)
    );

    assign full      = (bit_count == CNT_W'(MAX_BITS));
    assign short_len = (bit_count < CNT_W'(MIN_BITS));
    assign bad_len   = ovf | short_len;
    assign busy      = (state == ACCUM);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (en_check)  state_nxt = ACCUM;
            ACCUM:   if (!en_check) state_nxt = EVAL;
            EVAL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            crc       <= INIT;
            bit_count <= '0;
            ovf       <= 1'b0;
            done      <= 1'b0;
            crc_ok    <= 1'b0;
            crc_err   <= 1'b0;
            len_err   <= 1'b0;
            syndrome  <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en_check) begin
                        crc       <= bit_valid ? step_out : INIT;
                        bit_count <= bit_valid ? CNT_W'(1) : '0;
                        ovf       <= 1'b0;
                        crc_ok    <= 1'b0;
                        crc_err   <= 1'b0;
                        len_err   <= 1'b0;
                        syndrome  <= '0;
                    end
                end
                ACCUM: begin
                    if (en_check && bit_valid) begin
                        // Excess bits are flagged but never shifted.
                        if (full) begin
                            ovf <= 1'b1;
                        end else begin
                            crc       <= step_out;
                            bit_count <= bit_count + CNT_W'(1);
                        end
                    end
                end
                EVAL: begin
                    syndrome <= crc;
                    crc_err  <= (crc != '0);
                    len_err  <= bad_len;
                    crc_ok   <= (crc == '0) & ~bad_len;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crc7_serial_checker.sv
// Randomized self-checking bench for crc7_serial_checker against a
// polynomial long-division reference model.
module tb_crc7_serial_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       en_check;
    logic       bit_valid;
    logic       bit_in;
    logic       busy;
    logic       done;
    logic       crc_ok;
    logic       crc_err;
    logic       len_err;
    logic [7:0] bit_count;
    logic [6:0] syndrome;

    int total = 0;
    int bad   = 0;
    bit frame[$];

    crc7_serial_checker dut (
        .clk       (clk),
        .reset     (reset),
        .en_check  (en_check),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .busy      (busy),
        .done      (done),
        .crc_ok    (crc_ok),
        .crc_err   (crc_err),
        .len_err   (len_err),
        .bit_count (bit_count),
        .syndrome  (syndrome)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Remainder of (first n frame bits, then `extra` zeros) mod x^7+x^3+1.
    function automatic logic [6:0] divide(input int n, input int extra);
        int r = 0;
        for (int i = 0; i < n + extra; i++) begin
            r = (r << 1) | ((i < n) ? int'(frame[i]) : 0);
            if ((r & 'h80) != 0) r = r ^ 'h89;
        end
        return 7'(r);
    endfunction

    task automatic push_bits(input logic [63:0] v, input int w);
        for (int i = w - 1; i >= 0; i--) frame.push_back(v[i]);
    endtask

    task automatic append_crc();
        logic [6:0] c;
        c = divide(frame.size(), 7);
        push_bits({57'd0, c}, 7);
    endtask

    // Called at a negedge with the DUT idle; returns at the done cycle
    // (b2b) or one cycle later (otherwise).
    task automatic run_window(input string tag, input bit gaps,
                              input bit b2b);
        int n;
        int idx;
        int m;
        logic [6:0] syn;
        logic le;
        logic ce;
        n   = frame.size();
        m   = (n > 128) ? 128 : n;
        syn = divide(m, 7);
        le  = (n < 8) || (n > 128);
        ce  = (syn != 0);
        en_check  = 1'b1;
        bit_valid = (n > 0);
        bit_in    = (n > 0) ? frame[0] : 1'b0;
        idx       = (n > 0) ? 1 : 0;
        @(negedge clk);
        check({tag, "/clr"},
              {crc_ok, crc_err, len_err, syndrome, done}, 0);
        check({tag, "/busy"}, busy, 1);
        while (idx < n) begin
            if (gaps && $urandom_range(3) == 0) begin
                bit_valid = 1'b0;
            end else begin
                bit_valid = 1'b1;
                bit_in    = frame[idx];
                idx++;
            end
            @(negedge clk);
        end
        en_check  = 1'b0;
        bit_valid = 1'($urandom);
        bit_in    = 1'($urandom);
        @(negedge clk);
        check({tag, "/eval_done"}, done, 0);
        check({tag, "/eval_busy"}, busy, 0);
        en_check  = b2b;
        bit_valid = 1'b0;
        @(negedge clk);
        check({tag, "/done"}, done, 1);
        check({tag, "/cnt"}, bit_count, m);
        check({tag, "/syn"}, syndrome, syn);
        check({tag, "/crc_err"}, crc_err, ce);
        check({tag, "/len_err"}, len_err, le);
        check({tag, "/crc_ok"}, crc_ok, !ce && !le);
        if (!b2b) begin
            en_check  = 1'b0;
            bit_valid = 1'($urandom);
            bit_in    = 1'($urandom);
            @(negedge clk);
            check({tag, "/pulse"}, done, 0);
            check({tag, "/hold"}, {crc_ok, crc_err, len_err, syndrome},
                  {!ce && !le, ce, le, syn});
            bit_valid = 1'b0;
        end
    endtask

    task automatic load_cmd0();
        frame.delete();
        push_bits(64'h40_0000_0000, 40);
        push_bits(64'b1001010, 7);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        en_check  = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        repeat (2) @(negedge clk);
        check("reset", {busy, done, crc_ok, crc_err, len_err,
                        bit_count, syndrome}, 0);
        reset = 1'b0;
        @(negedge clk);

        load_cmd0();
        run_window("cmd0", 1'b0, 1'b0);
        check("cmd0/ok", crc_ok, 1);
        check("cmd0/zero", syndrome, 0);
        check("cmd0/47", bit_count, 47);

        frame.delete();
        push_bits(64'h51_0000_0000, 40);
        push_bits(64'h2A, 7);
        run_window("cmd17", 1'b1, 1'b0);
        check("cmd17/ok", crc_ok, 1);
        frame[10] = ~frame[10];
        run_window("cmd17f", 1'b1, 1'b0);
        check("cmd17f/err", crc_err, 1);

        frame.delete();
        for (int i = 0; i < 5; i++) frame.push_back(1'($urandom));
        run_window("short5", 1'b0, 1'b0);
        check("short5/len", len_err, 1);

        frame.delete();
        for (int i = 0; i < 130; i++) frame.push_back(1'($urandom));
        run_window("ovf130", 1'b1, 1'b0);
        check("ovf130/cnt", bit_count, 128);

        frame.delete();
        run_window("empty", 1'b0, 1'b0);

        load_cmd0();
        en_check  = 1'b1;
        bit_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bit_in = frame[i];
            @(negedge clk);
        end
        reset     = 1'b1;
        en_check  = 1'b0;
        bit_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("abort", {busy, done, crc_ok, crc_err, len_err,
                        bit_count, syndrome}, 0);
        repeat (3) begin
            @(negedge clk);
            check("abort/nodone", done, 0);
        end
        run_window("cmd0b", 1'b0, 1'b0);
        check("cmd0b/ok", crc_ok, 1);

        load_cmd0();
        run_window("b2b_a", 1'b0, 1'b1);
        frame.delete();
        for (int i = 0; i < 20; i++) frame.push_back(1'($urandom));
        append_crc();
        run_window("b2b_b", 1'b1, 1'b0);

        for (int t = 0; t < 12; t++) begin
            int len;
            frame.delete();
            len = ($urandom_range(7) == 0) ? $urandom_range(140, 1)
                                           : $urandom_range(100, 1);
            for (int i = 0; i < len; i++) frame.push_back(1'($urandom));
            if ($urandom_range(1) == 1) append_crc();
            run_window($sformatf("rnd%0d", t), 1'b1, 1'($urandom));
        end
        en_check = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
